pbus_initiator: RTL and testbench

- Initiator (master) end of the peripheral bus: turns one-outstanding load/store commands from the core-side into p_* transactions toward slave wrappers.
- Checks alignment and access size, aligns data lanes, and enforces a response timeout.
- Reports every bus error on soc_fault/soc_fault_cause/soc_fault_addr, which feed the reset controller's fault inputs.

---
 rtl/pbus_initiator.sv | 190 +++++++++++++++++++
 tb/tb_pbus_initiator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_initiator.sv
// Peripheral-bus initiator: one-outstanding core load/store to p_* transactions,
// with size/alignment checks, byte-lane steering, response timeout and fault reporting.
module pbus_initiator #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned ACC_W     = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [XLEN-1:0]      c_addr,
    input  logic                 c_w_rb,
    input  logic [ACC_W-1:0]     c_acc,
    input  logic [XLEN-1:0]      c_wdata,
    input  logic                 c_req,
    output logic                 c_ready,
    output logic [XLEN-1:0]      c_rdata,
    output logic                 c_done,
    output logic                 c_fault,
    output logic [XLEN-1:0]      p_addr,
    output logic                 p_w_rb,
    output logic [ACC_W-1:0]     p_acc,
    output logic [BUS_WIDTH-1:0] p_wdata,
    input  logic [BUS_WIDTH-1:0] p_rdata,
    output logic                 p_req,
    input  logic                 p_resp,
    input  logic                 p_fault,
    output logic                 soc_fault,
    output logic [7:0]           soc_fault_cause,
    output logic [XLEN-1:0]      soc_fault_addr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [7:0] CAUSE_ALIGN = 8'h01;
    localparam logic [7:0] CAUSE_SIZE  = 8'h02;
    localparam logic [7:0] CAUSE_TMO   = 8'h03;
    localparam logic [7:0] CAUSE_SLV   = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 c_ready_d, c_done_d, c_fault_d, soc_fault_d, p_req_d, p_w_rb_d;
    logic [XLEN-1:0]      c_rdata_d, p_addr_d, fault_addr_d;
    logic [ACC_W-1:0]     p_acc_d;
    logic [BUS_WIDTH-1:0] p_wdata_d;
    logic [7:0]           fault_cause_d;

    logic                 misaligned;
    logic [4:0]           wr_sh, rd_sh;
    logic [BUS_WIDTH-1:0] rd_shift;
    logic [XLEN-1:0]      rd_lane;

    // Alignment check and lane shift amounts
    always_comb begin
        misaligned = 1'b0;
        case (c_acc)
            ACC_W'(1): misaligned = c_addr[0];
            ACC_W'(2): misaligned = |c_addr[1:0];
            default:   misaligned = 1'b0;
        endcase
        wr_sh = {c_addr[1:0], 3'b000};
        rd_sh = {p_addr[1:0], 3'b000};
    end

    // Right-justify and zero-extend read data using the latched address/size
    always_comb begin
        rd_shift = p_rdata >> rd_sh;
        case (p_acc)
            ACC_W'(0): rd_lane = XLEN'(rd_shift[7:0]);
            ACC_W'(1): rd_lane = XLEN'(rd_shift[15:0]);
            default:   rd_lane = XLEN'(rd_shift);
        endcase
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        c_ready_d     = 1'b0;
        c_done_d      = 1'b0;
        c_fault_d     = 1'b0;
        c_rdata_d     = '0;
        soc_fault_d   = 1'b0;
        fault_cause_d = soc_fault_cause;
        fault_addr_d  = soc_fault_addr;
        p_req_d       = 1'b0;
        p_addr_d      = p_addr;
        p_w_rb_d      = p_w_rb;
        p_acc_d       = p_acc;
        p_wdata_d     = p_wdata;

        case (state)
            ST_IDLE: begin
                cnt_d     = '0;
                c_ready_d = 1'b1;
                if (c_req) begin
                    c_ready_d = 1'b0;
                    if (c_acc == ACC_W'(3) || misaligned) begin
                        state_d       = ST_ERR;
                        c_done_d      = 1'b1;
                        c_fault_d     = 1'b1;
                        soc_fault_d   = 1'b1;
                        fault_cause_d = (c_acc == ACC_W'(3)) ? CAUSE_SIZE : CAUSE_ALIGN;
                        fault_addr_d  = c_addr;
                    end else begin
                        state_d   = ST_WAIT;
                        p_req_d   = 1'b1;
                        p_addr_d  = c_addr;
                        p_w_rb_d  = c_w_rb;
                        p_acc_d   = c_acc;
                        p_wdata_d = c_w_rb ? (BUS_WIDTH'(c_wdata) << wr_sh) : '0;
                    end
                end
            end
            ST_WAIT: begin
                // cnt counts cycles elapsed since p_req; a response on the limit cycle still wins
                if (p_resp) begin
                    state_d   = ST_DONE;
                    c_done_d  = 1'b1;
                    c_fault_d = p_fault;
                    if (p_fault) begin
                        soc_fault_d   = 1'b1;
                        fault_cause_d = CAUSE_SLV;
                        fault_addr_d  = p_addr;
                    end else if (!p_w_rb) begin
                        c_rdata_d = rd_lane;
                    end
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT)) begin
                    state_d       = ST_ERR;
                    c_done_d      = 1'b1;
                    c_fault_d     = 1'b1;
                    soc_fault_d   = 1'b1;
                    fault_cause_d = CAUSE_TMO;
                    fault_addr_d  = p_addr;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                state_d   = ST_IDLE;
                c_ready_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                c_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            c_ready         <= 1'b1;
            c_done          <= 1'b0;
            c_fault         <= 1'b0;
            c_rdata         <= '0;
            soc_fault       <= 1'b0;
            soc_fault_cause <= '0;
            soc_fault_addr  <= '0;
            p_req           <= 1'b0;
            p_addr          <= '0;
            p_w_rb          <= 1'b0;
            p_acc           <= '0;
            p_wdata         <= '0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            c_ready         <= c_ready_d;
            c_done          <= c_done_d;
            c_fault         <= c_fault_d;
            c_rdata         <= c_rdata_d;
            soc_fault       <= soc_fault_d;
            soc_fault_cause <= fault_cause_d;
            soc_fault_addr  <= fault_addr_d;
            p_req           <= p_req_d;
            p_addr          <= p_addr_d;
            p_w_rb          <= p_w_rb_d;
            p_acc           <= p_acc_d;
            p_wdata         <= p_wdata_d;
        end
    end

endmodule

// File: tb/tb_pbus_initiator.sv
// Directed bench for pbus_initiator with a short response timeout.
module tb_pbus_initiator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] c_addr = '0;
    logic        c_w_rb = 1'b0;
    logic [1:0]  c_acc = '0;
    logic [31:0] c_wdata = '0;
    logic        c_req = 1'b0;
    logic        c_ready;
    logic [31:0] c_rdata;
    logic        c_done;
    logic        c_fault;
    logic [31:0] p_addr;
    logic        p_w_rb;
    logic [1:0]  p_acc;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata = '0;
    logic        p_req;
    logic        p_resp = 1'b0;
    logic        p_fault = 1'b0;
    logic        soc_fault;
    logic [7:0]  soc_fault_cause;
    logic [31:0] soc_fault_addr;

    int n_checks = 0;
    int n_fail   = 0;

    pbus_initiator #(
        .XLEN(32), .BUS_WIDTH(32), .ACC_W(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .c_addr(c_addr), .c_w_rb(c_w_rb), .c_acc(c_acc), .c_wdata(c_wdata),
        .c_req(c_req), .c_ready(c_ready), .c_rdata(c_rdata), .c_done(c_done),
        .c_fault(c_fault),
        .p_addr(p_addr), .p_w_rb(p_w_rb), .p_acc(p_acc), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_req(p_req), .p_resp(p_resp), .p_fault(p_fault),
        .soc_fault(soc_fault), .soc_fault_cause(soc_fault_cause),
        .soc_fault_addr(soc_fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sampling and driving happen 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns in cycle 1 (the p_req cycle)
    task automatic start_cmd(input logic [31:0] addr, input logic w, input logic [1:0] acc,
                             input logic [31:0] wdata);
        c_addr  = addr;
        c_w_rb  = w;
        c_acc   = acc;
        c_wdata = wdata;
        c_req   = 1'b1;
        step();
        c_req   = 1'b0;
    endtask

    // Pulse p_resp for one cycle; returns in the cycle after the response
    task automatic respond(input logic [31:0] rdata, input logic flt);
        p_rdata = rdata;
        p_fault = flt;
        p_resp  = 1'b1;
        step();
        p_resp  = 1'b0;
        p_fault = 1'b0;
        p_rdata = '0;
    endtask

    initial begin
        step();
        check("rst_c_ready", 32'(c_ready), 32'd1);
        check("rst_c_done", 32'(c_done), 32'd0);
        check("rst_p_req", 32'(p_req), 32'd0);
        check("rst_cause", 32'(soc_fault_cause), 32'd0);
        rstn = 1'b1;
        step();

        // Word read, response in cycle 3, completion in cycle 4
        start_cmd(32'h1000_0004, 1'b0, 2'd2, 32'h0);
        check("rd_p_req", 32'(p_req), 32'd1);
        check("rd_p_addr", p_addr, 32'h1000_0004);
        check("rd_p_wdata", p_wdata, 32'h0);
        check("rd_c_ready", 32'(c_ready), 32'd0);
        step();
        check("rd_p_req_pulse", 32'(p_req), 32'd0);
        check("rd_p_addr_hold", p_addr, 32'h1000_0004);
        step();
        respond(32'hDEAD_BEEF, 1'b0);
        check("rd_done", 32'(c_done), 32'd1);
        check("rd_rdata", c_rdata, 32'hDEAD_BEEF);
        check("rd_fault", 32'(c_fault), 32'd0);
        check("rd_soc_fault", 32'(soc_fault), 32'd0);
        step();
        check("rd_done_pulse", 32'(c_done), 32'd0);
        check("rd_ready_back", 32'(c_ready), 32'd1);

        // Byte write to lane 3
        start_cmd(32'h1000_0003, 1'b1, 2'd0, 32'h0000_00A5);
        check("bw_p_wdata", p_wdata, 32'hA500_0000);
        check("bw_p_acc", 32'(p_acc), 32'd0);
        check("bw_p_w_rb", 32'(p_w_rb), 32'd1);
        step();
        respond(32'h0, 1'b0);
        check("bw_done", 32'(c_done), 32'd1);
        check("bw_fault", 32'(c_fault), 32'd0);
        step();

        // Half read from upper half
        start_cmd(32'h1000_0002, 1'b0, 2'd1, 32'h0);
        step();
        respond(32'h1234_5678, 1'b0);
        check("hr_rdata", c_rdata, 32'h0000_1234);
        step();

        // Byte read from lane 1
        start_cmd(32'h1000_0001, 1'b0, 2'd0, 32'h0);
        step();
        respond(32'h1234_5678, 1'b0);
        check("br_rdata", c_rdata, 32'h0000_0056);
        step();

        // Misaligned half: error in cycle 1, no bus request
        start_cmd(32'h1000_0001, 1'b0, 2'd1, 32'h0);
        check("al_p_req", 32'(p_req), 32'd0);
        check("al_done", 32'(c_done), 32'd1);
        check("al_fault", 32'(c_fault), 32'd1);
        check("al_soc_fault", 32'(soc_fault), 32'd1);
        check("al_cause", 32'(soc_fault_cause), 32'h01);
        check("al_addr", soc_fault_addr, 32'h1000_0001);
        check("al_rdata", c_rdata, 32'h0);
        step();
        check("al_soc_pulse", 32'(soc_fault), 32'd0);
        check("al_cause_hold", 32'(soc_fault_cause), 32'h01);
        check("al_ready", 32'(c_ready), 32'd1);

        // Illegal size
        start_cmd(32'h1000_0000, 1'b1, 2'd3, 32'h1);
        check("sz_p_req", 32'(p_req), 32'd0);
        check("sz_done", 32'(c_done), 32'd1);
        check("sz_cause", 32'(soc_fault_cause), 32'h02);
        step();

        // Silent slave: cycles 2..5 are the four wait cycles, error shows in cycle 6
        start_cmd(32'h2000_0000, 1'b0, 2'd2, 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("to_not_yet", 32'(c_done), 32'd0);
        step();
        check("to_done", 32'(c_done), 32'd1);
        check("to_fault", 32'(c_fault), 32'd1);
        check("to_soc_fault", 32'(soc_fault), 32'd1);
        check("to_cause", 32'(soc_fault_cause), 32'h03);
        check("to_addr", soc_fault_addr, 32'h2000_0000);
        step();
        step();
        respond(32'hFFFF_FFFF, 1'b0);
        check("late_resp_done", 32'(c_done), 32'd0);
        check("late_resp_ready", 32'(c_ready), 32'd1);
        start_cmd(32'h3000_0008, 1'b1, 2'd2, 32'h0BAD_F00D);
        check("post_to_wdata", p_wdata, 32'h0BAD_F00D);
        check("post_to_p_req", 32'(p_req), 32'd1);
        step();
        respond(32'h0, 1'b0);
        check("post_to_done", 32'(c_done), 32'd1);
        check("post_to_fault", 32'(c_fault), 32'd0);
        step();

        // Slave error
        start_cmd(32'h4000_0000, 1'b0, 2'd2, 32'h0);
        step();
        respond(32'hFFFF_FFFF, 1'b1);
        check("sf_done", 32'(c_done), 32'd1);
        check("sf_fault", 32'(c_fault), 32'd1);
        check("sf_rdata", c_rdata, 32'h0);
        check("sf_soc_fault", 32'(soc_fault), 32'd1);
        check("sf_cause", 32'(soc_fault_cause), 32'h04);
        check("sf_addr", soc_fault_addr, 32'h4000_0000);
        step();

        // Response on the last allowed wait cycle completes normally
        start_cmd(32'h5000_0000, 1'b0, 2'd2, 32'h0);
        for (int i = 0; i < 4; i++) step();
        respond(32'hCAFE_F00D, 1'b0);
        check("bd_done", 32'(c_done), 32'd1);
        check("bd_fault", 32'(c_fault), 32'd0);
        check("bd_soc_fault", 32'(soc_fault), 32'd0);
        check("bd_rdata", c_rdata, 32'hCAFE_F00D);
        check("bd_cause_hold", 32'(soc_fault_cause), 32'h04);
        step();

        // Reset in the middle of a wait
        start_cmd(32'h6000_0000, 1'b0, 2'd2, 32'h0);
        rstn = 1'b0;
        #1;
        check("mr_p_req", 32'(p_req), 32'd0);
        check("mr_c_ready", 32'(c_ready), 32'd1);
        check("mr_p_addr", p_addr, 32'h0);
        check("mr_cause", 32'(soc_fault_cause), 32'h0);
        step();
        rstn = 1'b1;
        step();
        respond(32'h1111_1111, 1'b0);
        check("mr_stray_done", 32'(c_done), 32'd0);
        start_cmd(32'h7000_0004, 1'b0, 2'd2, 32'h0);
        check("mr_next_p_req", 32'(p_req), 32'd1);
        step();
        respond(32'h2468_ACE0, 1'b0);
        check("mr_next_done", 32'(c_done), 32'd1);
        check("mr_next_rdata", c_rdata, 32'h2468_ACE0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
